// File: rtl/trace_dump.sv
// -----------------------------------------------------------------------------
// trace_dump
//   After a capture completes, streams one channel's DEPTH-sample circular
//   trace out of capture RAM to the UART transmitter. The oldest sample
//   (trace_end+1) goes first and the newest (trace_end) goes last.
//
// Optional feature (compile-time macro DUMP_HDR_EN):
//   When defined, a header byte {6'b101010, ch_sel} is sent through the same
//   trmt/tx_done handshake before the first sample (HDR state).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   dump         single-cycle request to start a dump (ignored while busy)
//   ch_sel[1:0]  channel to dump: 0=CH1, 1=CH2, 2=CH3, 3=reserved (ignored)
//   trace_end    address of the last sample written by capture
//   dump_abort   terminate the current dump (goes to FIN, pulses dump_fin)
//   raddr        RAM read address shared by all channels
//   ren[2:0]     one-hot per-channel RAM read enable
//   rdata1..3    RAM read data, valid one cycle after ren
//   tx_data      byte presented to the UART
//   trmt         single-cycle transmit strobe
//   tx_done      UART finished the current byte
//   busy         dump in progress (every state except IDLE)
//   dump_fin     single-cycle completion pulse
// -----------------------------------------------------------------------------
module trace_dump #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump,
  input  logic [1:0]    ch_sel,
  input  logic [AW-1:0] trace_end,
  input  logic          dump_abort,
  output logic [AW-1:0] raddr,
  output logic [2:0]    ren,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] rdata3,
  output logic [DW-1:0] tx_data,
  output logic          trmt,
  input  logic          tx_done,
  output logic          busy,
  output logic          dump_fin
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
`ifdef DUMP_HDR_EN
  localparam logic [2:0] S_HDR  = 3'd5;
`endif

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [2:0]  state_r;
  logic [1:0]  ch_r;
  logic [AW:0] cnt_r;

  // Channel code to one-hot RAM enable; the reserved code enables nothing.
  function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
    case (ch)
      2'd0:    ch_onehot = 3'b001;
      2'd1:    ch_onehot = 3'b010;
      2'd2:    ch_onehot = 3'b100;
      default: ch_onehot = 3'b000;
    endcase
  endfunction

  // Pick the read data of the latched channel.
  function automatic logic [DW-1:0] ch_rdata(input logic [1:0]    ch,
                                             input logic [DW-1:0] d1,
                                             input logic [DW-1:0] d2,
                                             input logic [DW-1:0] d3);
    case (ch)
      2'd0:    ch_rdata = d1;
      2'd1:    ch_rdata = d2;
      2'd2:    ch_rdata = d3;
      default: ch_rdata = {DW{1'b0}};
    endcase
  endfunction

  // Dump sequencer: every output is registered. ren/trmt/dump_fin default
  // low so each is a one-cycle pulse set on entry to the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      ch_r     <= 2'd0;
      cnt_r    <= '0;
      raddr    <= '0;
      ren      <= 3'b000;
      tx_data  <= '0;
      trmt     <= 1'b0;
      busy     <= 1'b0;
      dump_fin <= 1'b0;
    end else begin
      ren      <= 3'b000;
      trmt     <= 1'b0;
      dump_fin <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (dump && (ch_sel != 2'd3)) begin
            ch_r  <= ch_sel;
            raddr <= trace_end + AW'(1);   // oldest sample, wraps modulo DEPTH
            cnt_r <= '0;
            busy  <= 1'b1;
`ifdef DUMP_HDR_EN
            tx_data <= DW'({6'b101010, ch_sel});
            trmt    <= 1'b1;
            state_r <= S_HDR;
`else
            ren     <= ch_onehot(ch_sel);
            state_r <= S_RD;
`endif
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
`ifdef DUMP_HDR_EN
        S_HDR: begin
          if (dump_abort) begin
            dump_fin <= 1'b1;
            state_r  <= S_FIN;
          end else if (tx_done) begin
            ren     <= ch_onehot(ch_r);
            state_r <= S_RD;
          end else begin
            state_r <= S_HDR;
          end
        end
`endif
        S_RD: begin
          // ren is already high for this cycle; the RAM answers during LAT
          if (dump_abort) begin
            dump_fin <= 1'b1;
            state_r  <= S_FIN;
          end else begin
            state_r <= S_LAT;
          end
        end
        S_LAT: begin
          if (dump_abort) begin
            dump_fin <= 1'b1;
            state_r  <= S_FIN;
          end else begin
            tx_data <= ch_rdata(ch_r, rdata1, rdata2, rdata3);
            trmt    <= 1'b1;
            raddr   <= raddr + AW'(1);
            cnt_r   <= cnt_r + (AW+1)'(1);
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          // abort wins over a coincident tx_done
          if (dump_abort) begin
            dump_fin <= 1'b1;
            state_r  <= S_FIN;
          end else if (tx_done) begin
            if (cnt_r == CNT_FULL) begin
              dump_fin <= 1'b1;
              state_r  <= S_FIN;
            end else begin
              ren     <= ch_onehot(ch_r);
              state_r <= S_RD;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_dump.sv
module tb_trace_dump;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 8;
`ifdef DUMP_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dump;
  logic [1:0]    ch_sel;
  logic [AW-1:0] trace_end;
  logic          dump_abort;
  logic [AW-1:0] raddr;
  logic [2:0]    ren;
  logic [DW-1:0] rdata1 = 8'h00;
  logic [DW-1:0] rdata2 = 8'h00;
  logic [DW-1:0] rdata3 = 8'h00;
  logic [DW-1:0] tx_data;
  logic          trmt;
  logic          tx_done = 1'b0;
  logic          busy;
  logic          dump_fin;

  trace_dump #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .dump(dump), .ch_sel(ch_sel), .trace_end(trace_end),
    .dump_abort(dump_abort), .raddr(raddr), .ren(ren), .rdata1(rdata1),
    .rdata2(rdata2), .rdata3(rdata3), .tx_data(tx_data), .trmt(trmt),
    .tx_done(tx_done), .busy(busy), .dump_fin(dump_fin)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Channel contents: CH1 = addr^0x55, CH2 = addr, CH3 = ~addr (low 8 bits)
  function automatic logic [7:0] exp_data(input logic [1:0] ch, input int a);
    logic [8:0] av;
    av = a[8:0];
    case (ch)
      2'd0:    exp_data = av[7:0] ^ 8'h55;
      2'd1:    exp_data = av[7:0];
      2'd2:    exp_data = ~av[7:0];
      default: exp_data = 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] exp_ren(input logic [1:0] ch);
    case (ch)
      2'd0:    exp_ren = 3'b001;
      2'd1:    exp_ren = 3'b010;
      2'd2:    exp_ren = 3'b100;
      default: exp_ren = 3'b000;
    endcase
  endfunction

  // RAM model, one cycle read latency
  always @(posedge clk) begin
    if (ren[0]) rdata1 <= exp_data(2'd0, int'(raddr));
    if (ren[1]) rdata2 <= exp_data(2'd1, int'(raddr));
    if (ren[2]) rdata3 <= exp_data(2'd2, int'(raddr));
  end

  // UART model: tx_done high 5 cycles after each trmt
  int dly = 0;
  always @(posedge clk) begin
    if (trmt) dly <= 4;
    else if (dly != 0) dly <= dly - 1;
    tx_done <= (dly == 1);
  end

  // Monitor: logs every transmitted byte and every RAM read
  logic [7:0]    tx_log   [0:4095];
  logic [2:0]    ren_log  [0:4095];
  logic [AW-1:0] addr_log [0:4095];
  int n_tx = 0, n_rd = 0, n_fin = 0, cyc = 0, last_done = 0, fin_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (trmt) begin
      tx_log[n_tx] <= tx_data;
      n_tx <= n_tx + 1;
    end
    if (|ren) begin
      ren_log[n_rd]  <= ren;
      addr_log[n_rd] <= raddr;
      n_rd <= n_rd + 1;
    end
    if (tx_done) last_done <= cyc;
    if (dump_fin) begin
      n_fin   <= n_fin + 1;
      fin_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Verify one complete dump against the channel contents
  task automatic check_run(input string tag, input int txb, input int rdb,
                           input int start, input logic [1:0] ch);
    int bad_b = 0;
    int bad_r = 0;
    int a;
    chk({tag, "_bytes"}, n_tx - txb, DEPTH + HB);
    chk({tag, "_reads"}, n_rd - rdb, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      a = (start + i) % DEPTH;
      if (tx_log[txb + HB + i] !== exp_data(ch, a)) bad_b++;
      if (ren_log[rdb + i] !== exp_ren(ch) || int'(addr_log[rdb + i]) != a) bad_r++;
    end
    chk({tag, "_data_errs"}, bad_b, 0);
    chk({tag, "_ren_addr_errs"}, bad_r, 0);
`ifdef DUMP_HDR_EN
    chk({tag, "_header"}, tx_log[txb], {6'b101010, ch});
`endif
  endtask

  initial begin
    int txb, rdb, fb, k;
    bit re;
    rst = 1'b1; dump = 1'b0; ch_sel = 2'd0; trace_end = '0; dump_abort = 1'b0;
    tick(); tick();
    chk("rst_raddr", raddr, 0);
    chk("rst_ren", ren, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dump_fin", dump_fin, 0);
    rst = 1'b0;
    tick();

    // reserved channel is ignored
    ch_sel = 2'd3; dump = 1'b1; tick(); dump = 1'b0;
    chk("ch3_busy", busy, 0);
    chk("ch3_ren", ren, 0);
    tick();
    chk("ch3_trmt", trmt, 0);

    // ---- full dump, CH2, trace_end=100, re-dump at sample 10 ----
    txb = n_tx; rdb = n_rd; fb = n_fin;
    trace_end = 9'd100; ch_sel = 2'd1; dump = 1'b1; tick(); dump = 1'b0;
`ifdef DUMP_HDR_EN
    chk("t1_hdr_trmt", trmt, 1);
    chk("t1_hdr_data", tx_data, 8'hA9);
    chk("t1_busy", busy, 1);
`else
    chk("t1_ren_first", ren, 3'b010);
    chk("t1_raddr_first", raddr, 101);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_ren_one_cycle", ren, 0);
    chk("t1_no_early_trmt", trmt, 0);
    tick();
    chk("t1_first_trmt", trmt, 1);
    chk("t1_first_data", tx_data, 8'd101);
    chk("t1_raddr_inc", raddr, 102);
`endif
    k = 0; re = 1'b0;
    while (n_fin == fb && k < 8000) begin
      if (!re && (n_tx - txb) == 10 + HB) begin
        ch_sel = 2'd0; dump = 1'b1; tick(); dump = 1'b0;
        re = 1'b1;
        chk("t1_redump_busy", busy, 1);
      end else begin
        tick();
      end
      k++;
    end
    chk("t1_redump_done", re, 1);
    chk("t1_fin_count", n_fin - fb, 1);
    chk("t1_fin_after_done", fin_cyc, last_done + 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_fin_single", dump_fin, 0);
    check_run("t1", txb, rdb, 101, 2'd1);

    // ---- trace_end=511 wraps: read 0..511, CH1 ----
    tick();
    txb = n_tx; rdb = n_rd; fb = n_fin;
    trace_end = 9'd511; ch_sel = 2'd0; dump = 1'b1; tick(); dump = 1'b0;
    k = 0;
    while (n_fin == fb && k < 8000) begin tick(); k++; end
    chk("t2_fin_count", n_fin - fb, 1);
    chk("t2_first_raddr", addr_log[rdb], 0);
    chk("t2_last_raddr", addr_log[rdb + DEPTH - 1], 511);
    chk("t2_last_byte", tx_log[txb + HB + DEPTH - 1], 8'hAA);
    check_run("t2", txb, rdb, 0, 2'd0);

    // ---- abort after 3rd trmt, coincident with tx_done, CH3 ----
    tick();
    txb = n_tx; fb = n_fin;
    trace_end = 9'd20; ch_sel = 2'd2; dump = 1'b1; tick(); dump = 1'b0;
    k = 0;
    while ((n_tx - txb) < 3 && k < 200) begin tick(); k++; end
    chk("t3_three_sent", n_tx - txb, 3);
    k = 0;
    while (!tx_done && k < 20) begin tick(); k++; end
    chk("t3_tx_done_seen", tx_done, 1);
    dump_abort = 1'b1; tick(); dump_abort = 1'b0;
    chk("t3_fin_pulse", dump_fin, 1);
    chk("t3_busy_in_fin", busy, 1);
    chk("t3_no_trmt", trmt, 0);
    tick();
    chk("t3_fin_low", dump_fin, 0);
    chk("t3_busy_after", busy, 0);
    repeat (30) tick();
    chk("t3_bytes_total", n_tx - txb, 3);
    chk("t3_fin_count", n_fin - fb, 1);

    // ---- reset at sample 200, then new dump from trace_end=5 ----
    txb = n_tx; fb = n_fin;
    trace_end = 9'd0; ch_sel = 2'd0; dump = 1'b1; tick(); dump = 1'b0;
    k = 0;
    while ((n_tx - txb) < 200 + HB && k < 3000) begin tick(); k++; end
    chk("t4_reached_200", n_tx - txb, 200 + HB);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_raddr", raddr, 0);
    chk("t4_ren", ren, 0);
    chk("t4_tx_data", tx_data, 0);
    chk("t4_trmt", trmt, 0);
    chk("t4_busy", busy, 0);
    chk("t4_dump_fin", dump_fin, 0);
    repeat (20) tick();
    chk("t4_no_fin", n_fin - fb, 0);
    rdb = n_rd; fb = n_fin;
    trace_end = 9'd5; ch_sel = 2'd1; dump = 1'b1; tick(); dump = 1'b0;
    chk("t4_new_raddr", raddr, 6);
    chk("t4_new_busy", busy, 1);
    repeat (20) tick();
    chk("t4_first_read_addr", addr_log[rdb], 6);
    chk("t4_first_read_ren", ren_log[rdb], 3'b010);
    dump_abort = 1'b1; tick(); dump_abort = 1'b0;
    chk("t4_abort_fin", dump_fin, 1);
    tick();
    chk("t4_abort_idle", busy, 0);
    chk("t4_fin_count", n_fin - fb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
